// File: rtl/fx_pkg.sv
// Shared definitions for the fixed-point MAC operand sequencer.
//   seq_state_t : sequencer FSM states
//   SEL_W/SEL_D : operand bank select encodings for wr_sel
//   addr_width  : operand index width for a K-entry bank
package fx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_STREAM,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    localparam logic SEL_W = 1'b0;
    localparam logic SEL_D = 1'b1;

    // A single-entry bank still gets a 1-bit index so ports never go zero-width.
    function automatic int unsigned addr_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/fx_seq_timer.sv
// Loadable up-counter with terminal-count flag, used as the WAIT timeout.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear the count to 0
//   en       : count one cycle (saturates at LIMIT)
//   last_c   : combinational; high while the current cycle's increment reaches LIMIT
module fx_seq_timer #(
    parameter int unsigned LIMIT = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last_c
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count register; load wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Flag the cycle that completes the LIMIT-th counted cycle.
    assign last_c = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fx_mac_seq.sv
// Operand sequencer and result collector for one fixed-point MAC.
// Holds K weight/data operand pairs, clears the MAC, streams the pairs,
// captures the MAC result pulse (or times out) and presents it with valid/ready.
//   clk, rst                          : clock, synchronous active-high reset
//   wr_en, wr_sel, wr_addr, wr_data   : operand bank write port (idle only)
//   start                             : begin a job (sampled in IDLE)
//   busy                              : high outside IDLE
//   mac_rstn, mac_vld, mac_win, mac_din : MAC input side (registered)
//   mac_acc, mac_done                 : MAC output side
//   res_o, res_err, res_vld, res_rdy  : result handshake
module fx_mac_seq
    import fx_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned K        = 2,
    parameter int unsigned FRACTION = 4,
    parameter int unsigned TMO      = 31,
    parameter int unsigned AW       = addr_width(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             mac_rstn,
    output logic             mac_vld,
    output logic [WIDTH-1:0] mac_win,
    output logic [WIDTH-1:0] mac_din,
    input  logic [WIDTH-1:0] mac_acc,
    input  logic             mac_done,
    output logic [WIDTH-1:0] res_o,
    output logic             res_err,
    output logic             res_vld,
    input  logic             res_rdy
);

    // Elaboration-time parameter sanity.
    if (K < 1) begin : g_bad_k
        $error("fx_mac_seq: K must be >= 1");
    end
    if (TMO < 1) begin : g_bad_tmo
        $error("fx_mac_seq: TMO must be >= 1");
    end
    if (FRACTION >= WIDTH) begin : g_bad_fraction
        $error("fx_mac_seq: FRACTION must be below WIDTH");
    end

    logic [WIDTH-1:0] wbank [K];
    logic [WIDTH-1:0] dbank [K];

    seq_state_t       state;
    seq_state_t       state_d;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_d;
    logic [WIDTH-1:0] res_o_d;
    logic             res_err_d;
    logic             stream_d;
    logic [WIDTH-1:0] mac_win_d;
    logic [WIDTH-1:0] mac_din_d;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_last_c;

    fx_seq_timer #(
        .LIMIT (TMO)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .en     (tmr_en),
        .last_c (tmr_last_c)
    );

    // Operand banks: written only while idle, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank <= '{default: '0};
            dbank <= '{default: '0};
        end else if (wr_en && !busy && (32'(wr_addr) < K)) begin
            if (wr_sel == SEL_W) begin
                wbank[wr_addr] <= wr_data;
            end else begin
                dbank[wr_addr] <= wr_data;
            end
        end
    end

    // Next state, next index and next result.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        res_o_d   = res_o;
        res_err_d = res_err;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                idx_d   = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (idx == AW'(K - 1)) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end else begin
                    idx_d = idx + AW'(1);
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                // A result pulse beats a simultaneous timeout.
                if (mac_done) begin
                    res_o_d   = mac_acc;
                    res_err_d = 1'b0;
                    state_d   = ST_HOLD;
                end else if (tmr_last_c) begin
                    res_o_d   = '0;
                    res_err_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign stream_d  = (state_d == ST_STREAM);
    assign mac_win_d = stream_d ? wbank[idx_d] : '0;
    assign mac_din_d = stream_d ? dbank[idx_d] : '0;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            mac_rstn <= 1'b0;
            mac_vld  <= 1'b0;
            mac_win  <= '0;
            mac_din  <= '0;
            res_o    <= '0;
            res_err  <= 1'b0;
            res_vld  <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            busy     <= (state_d != ST_IDLE);
            mac_rstn <= (state_d != ST_CLR);
            mac_vld  <= stream_d;
            mac_win  <= mac_win_d;
            mac_din  <= mac_din_d;
            res_o    <= res_o_d;
            res_err  <= res_err_d;
            res_vld  <= (state_d == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_fx_mac_seq.sv
// Directed bench for fx_mac_seq with a behavioural Q4.4 saturating MAC partner.
module tb_fx_mac_seq;
    import fx_pkg::*;

    localparam int WIDTH    = 8;
    localparam int K        = 2;
    localparam int FRACTION = 4;
    localparam int TMO      = 31;
    localparam int AW       = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic             wr_sel = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic             res_rdy = 1'b0;
    logic             busy;
    logic             mac_rstn;
    logic             mac_vld;
    logic [WIDTH-1:0] mac_win;
    logic [WIDTH-1:0] mac_din;
    logic [WIDTH-1:0] mac_acc;
    logic             mac_done;
    logic [WIDTH-1:0] res_o;
    logic             res_err;
    logic             res_vld;

    int checks = 0;
    int errors = 0;

    fx_mac_seq #(
        .WIDTH(WIDTH), .K(K), .FRACTION(FRACTION), .TMO(TMO), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy),
        .mac_rstn(mac_rstn), .mac_vld(mac_vld), .mac_win(mac_win), .mac_din(mac_din),
        .mac_acc(mac_acc), .mac_done(mac_done),
        .res_o(res_o), .res_err(res_err), .res_vld(res_vld), .res_rdy(res_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- MAC partner model ----------------
    logic signed [7:0] m_acc = '0;
    logic              m_done = 1'b0;
    logic              m_pend = 1'b0;
    int                m_cnt = 0;
    int                m_dly = 0;
    int                mac_delay = 0;
    bit                mac_dead = 1'b0;
    logic              stray_done = 1'b0;

    assign mac_done = m_done | stray_done;
    assign mac_acc  = stray_done ? 8'h55 : m_acc;

    function automatic logic signed [7:0] mac_step(input logic signed [7:0] acc,
                                                   input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
        logic signed [15:0] p;
        logic signed [17:0] s;
        p = a * b;
        s = 18'(acc) + 18'(p >>> FRACTION);
        if (s > 18'sd127) return 8'sh7F;
        else if (s < -18'sd128) return 8'sh80;
        else return s[7:0];
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!mac_rstn) begin
            m_acc  <= '0;
            m_cnt  <= 0;
            m_pend <= 1'b0;
            m_dly  <= 0;
        end else if (mac_vld) begin
            m_acc <= mac_step(m_acc, mac_win, mac_din);
            m_cnt <= m_cnt + 1;
            if (m_cnt == K - 1) begin
                if (mac_delay == 0) m_done <= !mac_dead;
                else begin
                    m_pend <= 1'b1;
                    m_dly  <= mac_delay;
                end
            end
        end else if (m_pend) begin
            if (m_dly <= 1) begin
                m_pend <= 1'b0;
                m_done <= !mac_dead;
            end else begin
                m_dly <= m_dly - 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] cap_w [4];
    logic [7:0] cap_d [4];
    int         zero_bad;
    logic       clr_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input logic sel, input logic [AW-1:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_banks(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] d0, input logic [7:0] d1);
        write_op(SEL_W, 1'b0, w0);
        write_op(SEL_W, 1'b1, w1);
        write_op(SEL_D, 1'b0, d0);
        write_op(SEL_D, 1'b1, d1);
    endtask

    // Starts a job and records the streamed pairs and start-to-res_vld latency (-1 on expiry).
    task automatic run_job(output int nvld, output int lat);
        nvld = 0; lat = -1; zero_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        clr_seen = (mac_rstn == 1'b0);
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (mac_vld) begin
                if (nvld < 4) begin
                    cap_w[nvld] = mac_win;
                    cap_d[nvld] = mac_din;
                end
                nvld++;
            end else if (mac_win != 8'h00 || mac_din != 8'h00) begin
                zero_bad++;
            end
            if (res_vld) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic release_result();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (mac_vld !== 1'b0) begin errors++; $display("FAIL reset mac_vld: got %b expected 0", mac_vld); end
        checks++; if (mac_win !== 8'h00 || mac_din !== 8'h00) begin errors++; $display("FAIL reset operands: got %h/%h expected 00/00", mac_win, mac_din); end
        checks++; if (res_o !== 8'h00) begin errors++; $display("FAIL reset res_o: got %h expected 00", res_o); end
        checks++; if (res_err !== 1'b0 || res_vld !== 1'b0) begin errors++; $display("FAIL reset res_err/res_vld: got %b/%b expected 0/0", res_err, res_vld); end
        checks++; if (mac_rstn !== 1'b0) begin errors++; $display("FAIL reset mac_rstn: got %b expected 0", mac_rstn); end
        rst = 1'b0;
        tick();
        checks++; if (mac_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post-reset mac_rstn/busy: got %b/%b expected 1/0", mac_rstn, busy); end
    endtask

    task automatic test_normal_job();
        int nvld, lat;
        load_banks(8'h10, 8'h20, 8'h18, 8'h08);
        run_job(nvld, lat);
        checks++; if (clr_seen !== 1'b1) begin errors++; $display("FAIL normal clr mac_rstn low: got %b expected 1", clr_seen); end
        checks++; if (nvld != 2) begin errors++; $display("FAIL normal vld count: got %0d expected 2", nvld); end
        checks++; if (cap_w[0] !== 8'h10 || cap_d[0] !== 8'h18) begin errors++; $display("FAIL normal pair0: got %h/%h expected 10/18", cap_w[0], cap_d[0]); end
        checks++; if (cap_w[1] !== 8'h20 || cap_d[1] !== 8'h08) begin errors++; $display("FAIL normal pair1: got %h/%h expected 20/08", cap_w[1], cap_d[1]); end
        checks++; if (zero_bad != 0) begin errors++; $display("FAIL normal idle operands nonzero: got %0d cycles expected 0", zero_bad); end
        checks++; if (lat != K + 2) begin errors++; $display("FAIL normal latency: got %0d expected %0d", lat, K + 2); end
        checks++; if (res_o !== 8'h28 || res_err !== 1'b0) begin errors++; $display("FAIL normal result: got %h err %b expected 28 err 0", res_o, res_err); end
        repeat (3) tick();
        checks++; if (res_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL normal hold: got vld %b busy %b expected 1/1", res_vld, busy); end
        release_result();
        checks++; if (res_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL normal release: got vld %b busy %b expected 0/0", res_vld, busy); end
    endtask

    task automatic test_protocol();
        int n, nvld, lat;
        start = 1'b1;
        tick();
        // start stays high and writes are attempted throughout the job
        wr_en = 1'b1; wr_sel = SEL_W; wr_addr = 1'b0; wr_data = 8'h33;
        repeat (3) tick();
        wr_sel = SEL_D; wr_addr = 1'b1; wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        n = 0;
        while (!res_vld && n < 50) begin tick(); n++; end
        checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL protocol res_vld timeout: got %b expected 1", res_vld); end
        checks++; if (res_o !== 8'h28) begin errors++; $display("FAIL protocol result: got %h expected 28", res_o); end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_vld !== 1'b1 || res_o !== 8'h28 || res_err !== 1'b0 || busy !== 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL backpressure stability: got %0d unstable cycles expected 0", n); end
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        checks++; if (res_o !== 8'h28 || res_err !== 1'b0 || res_vld !== 1'b1) begin errors++; $display("FAIL stray done: got %h err %b vld %b expected 28 0 1", res_o, res_err, res_vld); end
        start = 1'b0;
        release_result();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL protocol release busy: got %b expected 0", busy); end
        run_job(nvld, lat);
        checks++; if (cap_w[0] !== 8'h10 || cap_d[1] !== 8'h08) begin errors++; $display("FAIL busy writes dropped: got w0 %h d1 %h expected 10/08", cap_w[0], cap_d[1]); end
        checks++; if (res_o !== 8'h28 || lat != K + 2) begin errors++; $display("FAIL readback job: got %h lat %0d expected 28 lat %0d", res_o, lat, K + 2); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int nvld, lat, n;
        run_job(nvld, lat);
        checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL b2b first job vld: got %b expected 1", res_vld); end
        start = 1'b1; res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        checks++; if (res_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b exit: got vld %b busy %b expected 0/0", res_vld, busy); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || mac_rstn !== 1'b0) begin errors++; $display("FAIL b2b restart: got busy %b rstn %b expected 1/0", busy, mac_rstn); end
        n = 0;
        while (!res_vld && n < 100) begin tick(); n++; end
        checks++; if (n != K + 2 || res_o !== 8'h28) begin errors++; $display("FAIL b2b second job: got lat %0d res %h expected %0d/28", n, res_o, K + 2); end
        release_result();
    endtask

    task automatic test_timeout();
        int nvld, lat;
        mac_dead = 1'b1;
        run_job(nvld, lat);
        mac_dead = 1'b0;
        checks++; if (lat != K + 1 + TMO) begin errors++; $display("FAIL timeout latency: got %0d expected %0d", lat, K + 1 + TMO); end
        checks++; if (res_o !== 8'h00 || res_err !== 1'b1) begin errors++; $display("FAIL timeout result: got %h err %b expected 00 err 1", res_o, res_err); end
        release_result();
    endtask

    task automatic test_done_at_tmo();
        int nvld, lat;
        mac_delay = 5;
        run_job(nvld, lat);
        checks++; if (lat != K + 2 + 5 || res_o !== 8'h28 || res_err !== 1'b0) begin errors++; $display("FAIL delayed done: got lat %0d res %h err %b expected %0d 28 0", lat, res_o, res_err, K + 7); end
        release_result();
        mac_delay = TMO - 1;
        run_job(nvld, lat);
        mac_delay = 0;
        checks++; if (lat != K + 1 + TMO) begin errors++; $display("FAIL done-at-tmo latency: got %0d expected %0d", lat, K + 1 + TMO); end
        checks++; if (res_o !== 8'h28 || res_err !== 1'b0) begin errors++; $display("FAIL done-at-tmo priority: got %h err %b expected 28 err 0", res_o, res_err); end
        release_result();
    endtask

    task automatic test_saturation();
        int nvld, lat;
        load_banks(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        run_job(nvld, lat);
        checks++; if (cap_w[1] !== 8'h7F || cap_d[0] !== 8'h7F) begin errors++; $display("FAIL sat operands: got %h/%h expected 7f/7f", cap_w[1], cap_d[0]); end
        checks++; if (res_o !== 8'h7F || res_err !== 1'b0 || lat != K + 2) begin errors++; $display("FAIL sat result: got %h err %b lat %0d expected 7f 0 %0d", res_o, res_err, lat, K + 2); end
        release_result();
    endtask

    task automatic test_reset_mid_stream();
        int nvld, lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (mac_vld !== 1'b1 || mac_win !== 8'h7F) begin errors++; $display("FAIL mid-stream setup: got vld %b win %h expected 1/7f", mac_vld, mac_win); end
        rst = 1'b1;
        tick();
        checks++; if (mac_vld !== 1'b0 || busy !== 1'b0 || mac_rstn !== 1'b0) begin errors++; $display("FAIL mid-stream abort: got vld %b busy %b rstn %b expected 0/0/0", mac_vld, busy, mac_rstn); end
        tick();
        checks++; if (mac_rstn !== 1'b0) begin errors++; $display("FAIL mid-stream rstn held: got %b expected 0", mac_rstn); end
        rst = 1'b0;
        tick();
        checks++; if (mac_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid-stream recover: got rstn %b busy %b expected 1/0", mac_rstn, busy); end
        run_job(nvld, lat);
        checks++; if (nvld != 2 || cap_w[0] !== 8'h00 || cap_w[1] !== 8'h00 || cap_d[0] !== 8'h00 || cap_d[1] !== 8'h00) begin errors++; $display("FAIL banks cleared: got n %0d w %h %h d %h %h expected 2 zeros", nvld, cap_w[0], cap_w[1], cap_d[0], cap_d[1]); end
        checks++; if (res_o !== 8'h00 || res_err !== 1'b0 || lat != K + 2) begin errors++; $display("FAIL cleared job result: got %h err %b lat %0d expected 00 0 %0d", res_o, res_err, lat, K + 2); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_normal_job();
        test_protocol();
        test_back_to_back();
        test_timeout();
        test_done_at_tmo();
        test_saturation();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_mac_seq.md
# fx_mac_seq

Operand sequencer and result collector for the fixed-point MAC. Software-side logic loads a K-entry weight vector and a K-entry data vector into local registers. On `start`, the block clears the MAC, streams the K operand pairs back-to-back, and captures the MAC's single-cycle result pulse. It then holds the result behind a valid/ready handshake. It sits between the load/control path and one MAC instance, driving the MAC's input side and consuming its output side.

## Interface
- `WIDTH`, 8, operand and result bitwidth (signed fixed point).
- `K`, 2, number of operand pairs per job; must be ≥ 1.
- `FRACTION`, 4, fractional bits. Carried for the result's fixed-point scale; unused arithmetically.
- `TMO`, 31, max cycles in WAIT before a timeout error.
- `AW`, `(K>1)?$clog2(K):1`, operand address width (derived).
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  write target: 0 = weight bank, 1 = data bank.
- `wr_addr`  in  AW  operand index; values ≥ K are ignored.
- `wr_data`  in  WIDTH  signed operand value.
- `start`  in  1  begin a job; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `mac_rstn`  out  1  active-low clear to the MAC's `rstn`.
- `mac_vld`  out  1  operand-valid to the MAC's `vld_i`.
- `mac_win`  out  WIDTH  weight operand to the MAC.
- `mac_din`  out  WIDTH  data operand to the MAC.
- `mac_acc`  in  WIDTH  MAC result (`acc_o`).
- `mac_done`  in  1  MAC result pulse (`vld_o`).
- `res_o`  out  WIDTH  captured result.
- `res_err`  out  1  result invalid because of a timeout.
- `res_vld`  out  1  result available.
- `res_rdy`  in  1  consumer accepts the result.

## Operation
- Storage is two register banks, `wbank[K]` and `dbank[K]`.
  - Writes are accepted only when `busy`=0; writes while busy are dropped.
  - Contents persist across jobs and are cleared to 0 by `rst`.
- FSM states are IDLE, CLR, STREAM, WAIT, HOLD.
- IDLE:
  - `start`=1 moves to CLR.
- CLR (exactly 1 cycle):
  - `mac_rstn`=0.
  - Address counter is loaded with 0.
  - Next state is STREAM.
- STREAM (exactly K cycles):
  - `mac_vld`=1, `mac_win`=`wbank[idx]`, `mac_din`=`dbank[idx]`.
  - `idx` increments each cycle.
  - After the cycle with `idx`=K-1, move to WAIT.
- WAIT:
  - The timeout counter starts at 0 and increments every cycle.
  - On the first cycle with `mac_done`=1: `res_o`<=`mac_acc`, `res_err`<=0, move to HOLD.
  - If the counter reaches TMO first: `res_o`<=0, `res_err`<=1, move to HOLD.
  - If `mac_done` and counter==TMO occur in the same cycle, `mac_done` wins.
- HOLD:
  - `res_vld`=1; `res_o` and `res_err` are stable.
  - On `res_vld`&`res_rdy`, move to IDLE.
  - `start` is ignored in HOLD.
  - `mac_done` pulses arriving outside WAIT are ignored.
- Arithmetic: the block performs none. Operands pass through unmodified; the result is captured verbatim.

## Timing
- Reset values:
  - `busy`=0, `mac_vld`=0, `mac_win`=0, `mac_din`=0.
  - `res_o`=0, `res_err`=0, `res_vld`=0.
  - FSM in IDLE.
  - `mac_rstn`=0 while `rst`=1, and 1 otherwise outside CLR.
- `rst` mid-job aborts immediately to IDLE. The MAC is cleared through `mac_rstn` during reset.
- Job sequence:
  - `start` sampled at edge 0.
  - CLR in cycle 1.
  - `mac_vld` high in cycles 2..K+1.
  - WAIT from cycle K+2.
- Latency from `start` to `res_vld` is K+2+d cycles, where d is the MAC's response delay in WAIT.
- `mac_*` outputs are registered and change only on clock edges. `mac_win`/`mac_din` are 0 whenever `mac_vld`=0.
- `busy` rises the cycle after `start` is accepted and falls the cycle after the handshake.
- A new `start` in the cycle right after HOLD exits is accepted.

## Structure
- Shared package `fx_pkg`:
  - FSM state enum `seq_state_t`.
  - Bank-select constants `SEL_W`=0, `SEL_D`=1.
  - The AW derivation function.
- One sub-module: `fx_seq_timer`, a loadable up-counter with terminal-count flag, used for the WAIT timeout.
- The operand banks are inline.
- The MAC is not instantiated inside this block; both connect at the next level up.

## Test plan
- Normal job, with the real MAC as partner, WIDTH=8, FRACTION=4, K=2:
  - Stimulus: weights 0x10, 0x20; data 0x18, 0x08; `start`.
  - Required: `mac_vld` high exactly 2 cycles with pairs (0x10,0x18) then (0x20,0x08); `res_o`=0x28, `res_err`=0; `res_vld` held until `res_rdy`.
- Saturation job: weights 0x7F, 0x7F; data 0x7F, 0x7F -> `res_o`=0x7F, `res_err`=0.
- Timeout: stub MAC with `mac_done` tied low -> `res_vld` exactly TMO cycles after WAIT entry, `res_o`=0, `res_err`=1.
- Back-pressure and protocol:
  - Hold `res_rdy`=0 for 10 cycles -> `res_o`/`res_vld` stable throughout.
  - `start` and `wr_en` during busy -> ignored; bank contents unchanged on readback via the next job.
  - Stray `mac_done` in HOLD -> no change.
- Reset mid-STREAM: assert `rst` at the second STREAM cycle -> next cycle `mac_vld`=0, `busy`=0, `mac_rstn`=0 during `rst`, banks read as 0 on the following job.
